alu_issue_stage: RTL and testbench

Decode-and-issue pipeline stage that drives the ALU operand and operation interface. It accepts decoded instruction fields and register-file operands through a valid/ready handshake. For each accepted instruction it produces the 4-bit ALU operation code, SrcA and SrcB, and presents them registered to the ALU on an output valid/ready handshake. It sits between register read and execute, and a 2-entry skid buffer absorbs execute-side stalls without bubbles.

---
 rtl/alu_issue_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Decode-and-issue stage between register read and execute. Decodes the
// instruction fields into an ALU operation code plus SrcA/SrcB operands and
// presents them registered to the ALU. A two-entry skid buffer (output
// register + skid register) absorbs execute-side stalls without bubbles.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake for decoded instruction fields
//   opcode, funct3, funct7, imm12, rs1_data, rs2_data   instruction inputs
//   out_valid / out_ready output handshake towards execute
//   SrcA, SrcB, Operation ALU operands and operation code
//   illegal               presented entry was not decodable
//   illegal_count         saturating count of illegal entries transferred
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [11:0]              imm12,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [15:0]              illegal_count
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [DATA_WIDTH-1:0]    dec_a;
    logic [DATA_WIDTH-1:0]    dec_b;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ill;

    logic [DATA_WIDTH-1:0]    imm_sext;
    logic [DATA_WIDTH-1:0]    imm_shamt;

    assign imm_sext  = {{(DATA_WIDTH-12){imm12[11]}}, imm12};
    assign imm_shamt = {{(DATA_WIDTH-5){1'b0}}, imm12[4:0]};

    // Default is the illegal encoding; each legal case overrides it.
    always_comb begin
        dec_op  = '0;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b1;
        unique case (opcode)
            OP_R: begin
                dec_b = rs2_data;
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == F7_STD) begin
                            dec_op = 4'b0010; dec_ill = 1'b0;
                        end else if (funct7 == F7_ALT) begin
                            dec_op = 4'b0110; dec_ill = 1'b0;
                        end
                    end
                    3'b111: if (funct7 == F7_STD) begin dec_op = 4'b0000; dec_ill = 1'b0; end
                    3'b110: if (funct7 == F7_STD) begin dec_op = 4'b0001; dec_ill = 1'b0; end
                    3'b100: if (funct7 == F7_STD) begin dec_op = 4'b0101; dec_ill = 1'b0; end
                    3'b010: if (funct7 == F7_STD) begin dec_op = 4'b0111; dec_ill = 1'b0; end
                    default: ;
                endcase
            end
            OP_I: begin
                dec_b = imm_sext;
                unique case (funct3)
                    3'b000: begin dec_op = 4'b1100; dec_ill = 1'b0; end
                    3'b010: begin dec_op = 4'b0011; dec_ill = 1'b0; end
                    3'b111: begin dec_op = 4'b0000; dec_ill = 1'b0; end
                    3'b110: begin dec_op = 4'b0001; dec_ill = 1'b0; end
                    3'b100: begin dec_op = 4'b0101; dec_ill = 1'b0; end
                    3'b001: begin
                        dec_b = imm_shamt;
                        if (funct7 == F7_STD) begin dec_op = 4'b1001; dec_ill = 1'b0; end
                    end
                    3'b101: begin
                        dec_b = imm_shamt;
                        if (funct7 == F7_STD) begin
                            dec_op = 4'b1101; dec_ill = 1'b0;
                        end else if (funct7 == F7_ALT) begin
                            dec_op = 4'b0100; dec_ill = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OP_BR: begin
                if (funct3 == 3'b000) begin
                    dec_op  = 4'b1000;
                    dec_b   = rs2_data;
                    dec_ill = 1'b0;
                end
            end
            default: ;
        endcase
        if (dec_ill) begin
            dec_op = '0;
            dec_b  = '0;
        end else begin
            dec_a  = rs1_data;
        end
    end

    logic                     skid_valid;
    logic [DATA_WIDTH-1:0]    skid_a;
    logic [DATA_WIDTH-1:0]    skid_b;
    logic [OPCODE_LENGTH-1:0] skid_op;
    logic                     skid_ill;

    logic accept;
    logic out_fire;

    // in_ready depends only on skid state (plus reset), never on out_ready.
    assign in_ready = !skid_valid && !reset;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            SrcA          <= '0;
            SrcB          <= '0;
            Operation     <= '0;
            illegal       <= 1'b0;
            skid_valid    <= 1'b0;
            skid_a        <= '0;
            skid_b        <= '0;
            skid_op       <= '0;
            skid_ill      <= 1'b0;
            illegal_count <= '0;
        end else begin
            if (out_fire && illegal && (illegal_count != 16'hFFFF))
                illegal_count <= illegal_count + 16'd1;

            if (skid_valid) begin
                // in_ready is low here, so no acceptance can collide with the move.
                if (out_fire) begin
                    SrcA       <= skid_a;
                    SrcB       <= skid_b;
                    Operation  <= skid_op;
                    illegal    <= skid_ill;
                    skid_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!out_valid || out_fire) begin
                    SrcA      <= dec_a;
                    SrcB      <= dec_b;
                    Operation <= dec_op;
                    illegal   <= dec_ill;
                    out_valid <= 1'b1;
                end else begin
                    skid_a     <= dec_a;
                    skid_b     <= dec_b;
                    skid_op    <= dec_op;
                    skid_ill   <= dec_ill;
                    skid_valid <= 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        illegal;
    logic [15:0] illegal_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm12(imm12),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [11:0] imm, input logic [31:0] a, input logic [31:0] b);
        opcode = op; funct3 = f3; funct7 = f7; imm12 = imm; rs1_data = a; rs2_data = b;
        in_valid = 1'b1;
    endtask

    // advance one rising edge, then sample at the following falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int xfers;
        int budget;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; imm12 = '0; rs1_data = '0; rs2_data = '0;

        // reset state
        @(negedge clk);
        cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk("rst_op", Operation, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_count", illegal_count, 0);
        reset = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // back-to-back issue, out_ready held high
        out_ready = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000000, 12'h000, 32'd5, 32'd7);   // ADD
        cyc();
        chk("add_valid", out_valid, 1);
        chk("add_op", Operation, 4'b0010);
        chk("add_srca", SrcA, 5);
        chk("add_srcb", SrcB, 7);
        drive(7'b0110011, 3'b000, 7'b0100000, 12'h400, 32'd9, 32'd7);   // SUB
        cyc();
        chk("sub_valid", out_valid, 1);
        chk("sub_op", Operation, 4'b0110);
        chk("sub_srcb", SrcB, 7);
        drive(7'b0010011, 3'b101, 7'b0100000, 12'h405, 32'h80000000, 32'd123); // SRAI
        cyc();
        chk("srai_op", Operation, 4'b0100);
        chk("srai_srca", SrcA, 32'h80000000);
        chk("srai_srcb", SrcB, 32'h00000005);
        drive(7'b0010011, 3'b000, 7'b1111111, 12'hFFF, 32'd1, 32'd2);   // ADDI
        cyc();
        chk("addi_op", Operation, 4'b1100);
        chk("addi_srcb", SrcB, 32'hFFFFFFFF);
        drive(7'b0010011, 3'b001, 7'b0000000, 12'h01F, 32'd3, 32'd4);   // SLLI
        cyc();
        chk("slli_op", Operation, 4'b1001);
        chk("slli_srcb", SrcB, 32'h0000001F);
        drive(7'b1100011, 3'b000, 7'b0000000, 12'h000, 32'd8, 32'h55);  // BEQ
        cyc();
        chk("beq_op", Operation, 4'b1000);
        chk("beq_srcb", SrcB, 32'h55);
        drive(7'b0110011, 3'b010, 7'b0000000, 12'h000, 32'd6, 32'd9);   // SLT
        cyc();
        chk("slt_op", Operation, 4'b0111);
        chk("slt_illegal", illegal, 0);
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", out_valid, 0);

        // stall: three instructions offered with out_ready low
        out_ready = 1'b0;
        drive(7'b0110011, 3'b111, 7'b0000000, 12'h000, 32'd1, 32'd2);   // AND
        cyc();
        chk("st_a_op", Operation, 4'b0000);
        chk("st_a_srca", SrcA, 1);
        chk("st_a_ready", in_ready, 1);
        drive(7'b0110011, 3'b110, 7'b0000000, 12'h000, 32'd3, 32'd4);   // OR
        cyc();
        chk("st_b_ready", in_ready, 0);
        chk("st_b_hold_srca", SrcA, 1);
        drive(7'b0110011, 3'b100, 7'b0000000, 12'h000, 32'd5, 32'd6);   // XOR
        cyc();
        chk("st_c_ready", in_ready, 0);
        chk("st_c_hold_srca", SrcA, 1);
        chk("st_c_hold_srcb", SrcB, 2);
        chk("st_c_hold_op", Operation, 4'b0000);
        out_ready = 1'b1;
        cyc();
        chk("rel_b_op", Operation, 4'b0001);
        chk("rel_b_srca", SrcA, 3);
        chk("rel_b_ready", in_ready, 1);
        cyc();
        chk("rel_c_op", Operation, 4'b0101);
        chk("rel_c_srca", SrcA, 5);
        chk("rel_c_srcb", SrcB, 6);
        in_valid = 1'b0;
        cyc();
        chk("rel_empty", out_valid, 0);

        // illegal decode
        out_ready = 1'b0;
        drive(7'b0110111, 3'b000, 7'b0000000, 12'h123, 32'h1234, 32'h5678);
        cyc();
        in_valid = 1'b0;
        chk("ill_flag", illegal, 1);
        chk("ill_op", Operation, 0);
        chk("ill_srca", SrcA, 0);
        chk("ill_srcb", SrcB, 0);
        chk("ill_cnt0", illegal_count, 0);
        cyc();
        chk("ill_cnt_stall", illegal_count, 0);
        out_ready = 1'b1;
        cyc();
        chk("ill_cnt1", illegal_count, 1);
        chk("ill_drained", out_valid, 0);
        drive(7'b0110011, 3'b111, 7'b0100000, 12'h000, 32'd1, 32'd1);   // AND with bad funct7
        cyc();
        in_valid = 1'b0;
        chk("ill_f7_flag", illegal, 1);
        cyc();
        chk("ill_cnt2", illegal_count, 2);

        // saturation: stream illegal entries until well past 0xFFFF transfers
        drive(7'b0000000, 3'b000, 7'b0000000, 12'h000, 32'd0, 32'd0);
        xfers = 0;
        budget = 0;
        while (xfers < 65537 && budget < 70000) begin
            @(posedge clk);
            #1;
            if (out_valid) xfers++;
            budget++;
        end
        chk("sat_budget", (budget < 70000), 1);
        in_valid = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        chk("sat_count", illegal_count, 16'hFFFF);

        // reset with both buffers full
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0000000, 12'h000, 32'd10, 32'd11);
        cyc();
        drive(7'b0110011, 3'b110, 7'b0000000, 12'h000, 32'd12, 32'd13);
        cyc();
        in_valid = 1'b0;
        chk("full_ready", in_ready, 0);
        chk("full_valid", out_valid, 1);
        reset = 1'b1;
        #1 chk("rst_full_ready", in_ready, 0);
        cyc();
        chk("rst_full_valid", out_valid, 0);
        chk("rst_full_ready2", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("after_rst_ready", in_ready, 1);
        chk("after_rst_count", illegal_count, 0);
        chk("after_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        cyc();
        chk("after_rst_no_ghost", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
